// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq: handshaked integer ALU with an iterative multiply/divide unit.
//  Base OP/OP-IMM operations register their result one cycle after the
//  input handshake. M-extension ops run XLEN radix-2 iterations:
//  shift-add for multiply and restoring division for divide. Divide by
//  zero and signed overflow finish in one cycle.
// Ports:
//  clk, rst             clock, synchronous active-high reset
//  in_valid / in_ready  request handshake (in_ready only in IDLE, rst low)
//  opcode/funct3/funct7 operation encoding
//  rs1, rs2             operands (rs2 = sign-extended immediate for OP-IMM)
//  out_valid/out_ready  result handshake; rd is held until it is consumed
//  rd                   result
module alu_mdu_seq #(
    parameter int unsigned XLEN     = 32,
    parameter bit          ENABLE_M = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rd
);

    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned PW  = 2 * XLEN;

    localparam logic [6:0]      OPC_OP    = 7'b0110011;
    localparam logic [6:0]      OPC_OPIMM = 7'b0010011;
    localparam logic [6:0]      F7_MEXT   = 7'b0000001;
    localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [SHW-1:0]  CNT_LAST  = SHW'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    // acc holds {hi, lo}: {partial product, multiplier} or {remainder, quotient}
    logic [PW-1:0]   acc_q, acc_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic [2:0]      mop_q, mop_d;
    logic            negres_q, negres_d;
    logic            negrem_q, negrem_d;
    logic [XLEN-1:0] rd_q, rd_d;

    logic            is_op, is_opimm, is_mext, div_ovf;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] base_res;
    logic            s1, s2;
    logic [XLEN-1:0] abs1, abs2;
    logic [XLEN:0]   mul_sum, rem_sh, trial;
    logic [PW-1:0]   acc_mul, acc_div, acc_nxt, prod;
    logic [XLEN-1:0] quo, rem, fin_res;

    // Operation decode from the live request inputs
    always_comb begin
        is_op    = (opcode == OPC_OP);
        is_opimm = (opcode == OPC_OPIMM);
        is_mext  = is_op && (funct7 == F7_MEXT);
        div_ovf  = funct3[2] && !funct3[0] && (rs1 == INT_MIN) && (rs2 == '1);
        shamt    = rs2[SHW-1:0];
    end

    // Single-cycle base operation result
    always_comb begin
        base_res = '0;
        unique case (funct3)
            3'b000: base_res = (is_op && funct7[5]) ? (rs1 - rs2) : (rs1 + rs2);
            3'b001: base_res = rs1 << shamt;
            3'b010: base_res = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
            3'b011: base_res = {{(XLEN-1){1'b0}}, (rs1 < rs2)};
            3'b100: base_res = rs1 ^ rs2;
            3'b101: base_res = funct7[5] ? XLEN'($signed(rs1) >>> shamt) : (rs1 >> shamt);
            3'b110: base_res = rs1 | rs2;
            3'b111: base_res = rs1 & rs2;
            default: base_res = '0;
        endcase
    end

    // Operand signs and magnitudes for the iterative unit
    always_comb begin
        s1 = 1'b0;
        s2 = 1'b0;
        if (funct3[2]) begin
            // DIV/REM signed, DIVU/REMU unsigned
            s1 = !funct3[0] && rs1[XLEN-1];
            s2 = !funct3[0] && rs2[XLEN-1];
        end else begin
            // MUL/MULH/MULHSU treat rs1 as signed; only MUL/MULH sign rs2
            s1 = (funct3[1:0] != 2'b11) && rs1[XLEN-1];
            s2 = !funct3[1] && rs2[XLEN-1];
        end
        abs1 = s1 ? (-rs1) : rs1;
        abs2 = s2 ? (-rs2) : rs2;
    end

    // One radix-2 step of multiply or divide, plus the final sign fix-up
    always_comb begin
        mul_sum = {1'b0, acc_q[PW-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        acc_mul = {mul_sum, acc_q[XLEN-1:1]};

        rem_sh  = {acc_q[PW-1:XLEN], acc_q[XLEN-1]};
        trial   = rem_sh - {1'b0, opb_q};
        if (!trial[XLEN]) begin
            acc_div = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            acc_div = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end

        acc_nxt = mop_q[2] ? acc_div : acc_mul;
        prod    = negres_q ? (-acc_nxt) : acc_nxt;
        quo     = acc_nxt[XLEN-1:0];
        rem     = acc_nxt[PW-1:XLEN];

        if (mop_q[2]) begin
            if (mop_q[1]) begin
                fin_res = negrem_q ? (-rem) : rem;
            end else begin
                fin_res = negres_q ? (-quo) : quo;
            end
        end else begin
            fin_res = (mop_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[PW-1:XLEN];
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        mop_d    = mop_q;
        negres_d = negres_q;
        negrem_d = negrem_q;
        rd_d     = rd_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_DONE;
                    if (!(is_op || is_opimm)) begin
                        rd_d = '0;
                    end else if (is_mext) begin
                        if (!ENABLE_M) begin
                            rd_d = '0;
                        end else if (funct3[2] && (rs2 == '0)) begin
                            rd_d = funct3[1] ? rs1 : '1;
                        end else if (div_ovf) begin
                            rd_d = funct3[1] ? '0 : INT_MIN;
                        end else begin
                            state_d  = S_CALC;
                            cnt_d    = '0;
                            acc_d    = {{XLEN{1'b0}}, abs1};
                            opb_d    = abs2;
                            mop_d    = funct3;
                            negres_d = s1 ^ s2;
                            negrem_d = s1;
                        end
                    end else begin
                        rd_d = base_res;
                    end
                end
            end
            S_CALC: begin
                acc_d = acc_nxt;
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    rd_d    = fin_res;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            mop_q    <= '0;
            negres_q <= 1'b0;
            negrem_q <= 1'b0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            mop_q    <= mop_d;
            negres_q <= negres_d;
            negrem_q <= negrem_d;
            rd_q     <= rd_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign rd        = rd_q;

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Testbench for alu_mdu_seq (XLEN=32): directed vector table, random ops
// against an arithmetic reference model, back-pressure and reset sequences.
module tb_alu_mdu_seq;

    localparam logic [6:0] OP  = 7'b0110011;
    localparam logic [6:0] IMM = 7'b0010011;
    localparam logic [6:0] MX  = 7'b0000001;
    localparam logic [6:0] ALT = 7'b0100000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2, rd;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_mdu_seq #(.XLEN(32), .ENABLE_M(1'b1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rs1(rs1), .rs2(rs2),
        .out_valid(out_valid), .out_ready(out_ready),
        .rd(rd)
    );

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference result computed from the operation's arithmetic meaning
    function automatic logic [31:0] ref_model(input logic [6:0] o, input logic [2:0] f3,
                                              input logic [6:0] f7, input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sa, sb, p;
        longint unsigned ua, ub, up;
        int              sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        sh = int'(b[4:0]);
        if (o != OP && o != IMM) return 32'd0;
        if (o == OP && f7 == MX) begin
            case (f3)
                3'd0: begin p = sa * sb; return p[31:0]; end
                3'd1: begin p = sa * sb; return p[63:32]; end
                3'd2: begin p = sa * longint'(ub); return p[63:32]; end
                3'd3: begin up = ua * ub; return up[63:32]; end
                3'd4: begin
                    if (b == 32'd0) return 32'hFFFFFFFF;
                    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                    p = sa / sb; return p[31:0];
                end
                3'd5: begin
                    if (b == 32'd0) return 32'hFFFFFFFF;
                    up = ua / ub; return up[31:0];
                end
                3'd6: begin
                    if (b == 32'd0) return a;
                    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                    p = sa % sb; return p[31:0];
                end
                default: begin
                    if (b == 32'd0) return a;
                    up = ua % ub; return up[31:0];
                end
            endcase
        end
        case (f3)
            3'd0: return (o == OP && f7[5]) ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return (sa < sb) ? 32'd1 : 32'd0;
            3'd3: return (ua < ub) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: begin
                if (f7[5]) begin p = sa >>> sh; return p[31:0]; end
                return a >> sh;
            end
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [6:0] o, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] b, input logic [6:0] f7);
        if (o == OP && f7 == MX) begin
            if (f3[2] && b == 32'd0) return 1;
            if (f3[2] && !f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
            return 33;
        end
        return 1;
    endfunction

    // Issue one op, scramble inputs while it runs, return result and latency
    task automatic run_op(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        opcode   = o;
        funct3   = f3;
        funct7   = f7;
        rs1      = a;
        rs2      = b;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            n_vec++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready got 0, expected 1");
        end
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            in_valid = 1'($urandom);
            opcode   = ($urandom_range(0, 1) == 0) ? OP : 7'($urandom);
            funct3   = 3'($urandom);
            funct7   = ($urandom_range(0, 1) == 0) ? MX : 7'($urandom);
            rs1      = $urandom;
            rs2      = $urandom;
        end while (!out_valid && lat < 100);
        res       = rd;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            5: return 32'($urandom_range(0, 40));
            6: return -32'($urandom_range(1, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res;
        int          lat;
        logic [6:0]  o, f7;
        logic [2:0]  f3;
        logic [31:0] a, b;
        int          r;
        logic        seen;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        opcode = '0; funct3 = '0; funct7 = '0; rs1 = '0; rs2 = '0;
        repeat (3) @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_rd", rd, 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("post_reset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        vt.push_back('{OP,  3'd0, 7'h00, 32'd5,          32'd7,          32'd12,         1});
        vt.push_back('{OP,  3'd0, ALT,   32'd5,          32'd7,          32'hFFFFFFFE,   1});
        vt.push_back('{IMM, 3'd0, ALT,   32'd5,          32'd7,          32'd12,         1});
        vt.push_back('{OP,  3'd5, ALT,   32'h80000000,   32'd4,          32'hF8000000,   1});
        vt.push_back('{OP,  3'd5, 7'h00, 32'h80000000,   32'd4,          32'h08000000,   1});
        vt.push_back('{IMM, 3'd5, ALT,   32'h80000000,   32'd4,          32'hF8000000,   1});
        vt.push_back('{OP,  3'd5, ALT,   32'h80000000,   32'd36,         32'hF8000000,   1});
        vt.push_back('{OP,  3'd2, 7'h00, 32'hFFFFFFFF,   32'd1,          32'd1,          1});
        vt.push_back('{OP,  3'd3, 7'h00, 32'hFFFFFFFF,   32'd1,          32'd0,          1});
        vt.push_back('{OP,  3'd3, 7'h00, 32'd1,          32'hFFFFFFFF,   32'd1,          1});
        vt.push_back('{OP,  3'd1, 7'h00, 32'd1,          32'd31,         32'h80000000,   1});
        vt.push_back('{OP,  3'd0, MX,    32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          33});
        vt.push_back('{OP,  3'd1, MX,    32'hFFFFFFFF,   32'hFFFFFFFF,   32'd0,          33});
        vt.push_back('{OP,  3'd3, MX,    32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   33});
        vt.push_back('{OP,  3'd2, MX,    32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF,   33});
        vt.push_back('{OP,  3'd4, MX,    -32'd7,         32'd2,          -32'd3,         33});
        vt.push_back('{OP,  3'd6, MX,    -32'd7,         32'd2,          -32'd1,         33});
        vt.push_back('{OP,  3'd4, MX,    32'd7,          32'd0,          32'hFFFFFFFF,   1});
        vt.push_back('{OP,  3'd7, MX,    32'd7,          32'd0,          32'd7,          1});
        vt.push_back('{OP,  3'd4, MX,    32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1});
        vt.push_back('{OP,  3'd6, MX,    32'h80000000,   32'hFFFFFFFF,   32'd0,          1});
        vt.push_back('{OP,  3'd5, MX,    32'd100,        32'd7,          32'd14,         33});
        vt.push_back('{OP,  3'd7, MX,    32'd100,        32'd7,          32'd2,          33});
        vt.push_back('{7'b0000011, 3'd0, 7'h00, 32'd5,   32'd7,          32'd0,          1});

        foreach (vt[i]) begin
            run_op(vt[i].opc, vt[i].f3, vt[i].f7, vt[i].a, vt[i].b, res, lat);
            check($sformatf("vec%0d_rd", i), res, vt[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].lat));
        end

        // Random ops against the reference model
        for (int i = 0; i < 300; i++) begin
            r  = $urandom_range(0, 9);
            o  = (r == 0) ? 7'($urandom) : ((r < 4) ? IMM : OP);
            f3 = 3'($urandom);
            r  = $urandom_range(0, 3);
            f7 = (r == 0) ? 7'h00 : ((r == 1) ? ALT : ((r == 2) ? MX : 7'($urandom)));
            a  = pick();
            b  = pick();
            run_op(o, f3, f7, a, b, res, lat);
            check($sformatf("rand%0d_rd op=%h f3=%0d f7=%h a=%h b=%h", i, o, f3, f7, a, b),
                  res, ref_model(o, f3, f7, a, b));
            check($sformatf("rand%0d_latency", i), 32'(lat), 32'(ref_lat(o, f3, a, b, f7)));
        end

        // Back-pressure: result held while out_ready is low, new requests ignored
        in_valid = 1'b1; opcode = OP; funct3 = 3'd0; funct7 = 7'h00; rs1 = 32'd3; rs2 = 32'd4;
        @(posedge clk);
        @(negedge clk);
        rs1 = 32'd100; rs2 = 32'd200;
        check("stall_first_valid", 32'(out_valid), 32'd1);
        check("stall_first_rd", rd, 32'd7);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d_rd", k), rd, 32'd7);
            check($sformatf("stall%0d_out_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("stall%0d_in_ready", k), 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_out_valid", 32'(out_valid), 32'd0);
        run_op(OP, 3'd0, 7'h00, 32'd100, 32'd200, res, lat);
        check("after_stall_rd", res, 32'd300);
        check("after_stall_latency", 32'(lat), 32'd1);

        // Reset in the middle of a DIVU
        run_op(OP, 3'd0, 7'h00, 32'd1, 32'd2, res, lat);
        check("pre_reset_rd", res, 32'd3);
        in_valid = 1'b1; opcode = OP; funct3 = 3'd5; funct7 = MX; rs1 = 32'd1000; rs2 = 32'd7;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_rd", rd, 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("abort_release_in_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_stale_result", 32'(seen), 32'd0);
        run_op(OP, 3'd5, MX, 32'd1000, 32'd7, res, lat);
        check("post_abort_divu_rd", res, 32'd142);
        check("post_abort_divu_latency", 32'(lat), 32'd33);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
